mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_if.sv | 49 ++++
 rtl/mem_stage.sv | 136 +++++++++++++
 tb/tb_mem_stage.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Shared RV32I type definitions and the data-memory bus between the MEM
// stage (master) and the data memory (slave).

package rv32i_types;

    typedef logic [31:0] rv32i_word;
    typedef logic [4:0]  rv32i_reg;

    // Only the fields the MEM stage consumes are carried here.
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
        logic       load_regfile;
    } rv32i_control_word;

    // Load/store funct3 encodings.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

interface mem_stage_if;
    import rv32i_types::*;

    rv32i_word  dmem_address;
    logic       dmem_read;
    logic       dmem_write;
    rv32i_word  dmem_wdata;
    logic [3:0] dmem_byte_enable;
    rv32i_word  dmem_rdata;
    logic       dmem_resp;

    // The pipeline side issues requests.
    modport master (
        output dmem_address, dmem_read, dmem_write, dmem_wdata, dmem_byte_enable,
        input  dmem_rdata, dmem_resp
    );

    // The memory side answers them.
    modport slave (
        input  dmem_address, dmem_read, dmem_write, dmem_wdata, dmem_byte_enable,
        output dmem_rdata, dmem_resp
    );

endinterface

// File: rtl/mem_stage.sv
// RV32I MEM stage: issues data-memory loads/stores, stalls the front of the
// pipe while an access is outstanding, formats load data and lane-aligns
// store data.
// Optional build macro MISALIGN_TRAP_EN: when defined, misaligned half/word
// accesses are suppressed and flagged on mem_misaligned.

module mem_stage
    import rv32i_types::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_valid,
    input  rv32i_control_word  MEM_ctrlword,
    input  rv32i_word          MEM_alu_out,
    input  rv32i_word          MEM_rs2_data,
    input  rv32i_reg           MEM_rd_num,
    input  logic               pipe_hold,
    mem_stage_if.master        dmem,
    output logic               mem_stall,
    output rv32i_word          MEM_rd_data,
    output logic               MEM_load_regfile
`ifdef MISALIGN_TRAP_EN
    ,output logic              mem_misaligned
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t    state_q, state_d;
    rv32i_word load_q, load_d;

    logic      is_access;
    logic      misaligned;
    logic      mem_go;
    logic      req_active;
    logic      is_load;
    logic      is_store;
    logic      unused_rd_num;

    // The destination register only travels alongside; nothing here needs it.
    assign unused_rd_num = ^MEM_rd_num;

    // Extract and extend the addressed byte/halfword from the returned word.
    function automatic rv32i_word format_load(input logic [2:0] funct3,
                                              input logic [1:0] offset,
                                              input rv32i_word  word);
        rv32i_word   shifted;
        logic [15:0] half;
        shifted = word >> {offset, 3'b000};
        half    = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    format_load = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   format_load = {24'h0, shifted[7:0]};
            F3_H:    format_load = {{16{half[15]}}, half};
            F3_HU:   format_load = {16'h0, half};
            default: format_load = word;
        endcase
    endfunction

    // A control word with both strobes set is treated as a load.
    assign is_load   = MEM_ctrlword.mem_read;
    assign is_store  = MEM_ctrlword.mem_write & ~MEM_ctrlword.mem_read;
    assign is_access = MEM_valid & (is_load | is_store);

`ifdef MISALIGN_TRAP_EN
    // Halfword needs addr[0]=0, word needs addr[1:0]=0; bytes never trap.
    assign misaligned = is_access &
        ((((MEM_ctrlword.funct3 == F3_H) || (MEM_ctrlword.funct3 == F3_HU)) && MEM_alu_out[0]) ||
         ((MEM_ctrlword.funct3 == F3_W) && (MEM_alu_out[1:0] != 2'b00)));
    assign mem_misaligned = ~rst & (state_q == IDLE) & misaligned;
`else
    assign misaligned = 1'b0;
`endif

    assign mem_go = is_access & ~misaligned;

    // Next-state and load-capture logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        load_d  = load_q;
        case (state_q)
            IDLE: if (mem_go) state_d = BUSY;
            BUSY: begin
                if (dmem.dmem_resp) begin
                    state_d = DONE;
                    load_d  = format_load(MEM_ctrlword.funct3, MEM_alu_out[1:0], dmem.dmem_rdata);
                end
            end
            DONE: if (!pipe_hold) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and load-result registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q <= IDLE;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
        end
    end

    // Request is raised in the issuing IDLE cycle and held through the resp cycle.
    assign req_active = ~rst & (((state_q == IDLE) & mem_go) | (state_q == BUSY));

    assign dmem.dmem_address = {MEM_alu_out[31:2], 2'b00};
    assign dmem.dmem_read    = req_active & is_load;
    assign dmem.dmem_write   = req_active & is_store;
    assign mem_stall         = req_active;

    // Lane-align store data and build the byte-enable mask.
    always_comb begin
        dmem.dmem_wdata       = MEM_rs2_data;
        dmem.dmem_byte_enable = 4'b0000;
        case (MEM_ctrlword.funct3[1:0])
            2'b00:   dmem.dmem_wdata = MEM_rs2_data << {MEM_alu_out[1:0], 3'b000};
            2'b01:   dmem.dmem_wdata = MEM_rs2_data << {MEM_alu_out[1], 4'b0000};
            default: dmem.dmem_wdata = MEM_rs2_data;
        endcase
        if (dmem.dmem_write) begin
            case (MEM_ctrlword.funct3[1:0])
                2'b00:   dmem.dmem_byte_enable = 4'b0001 << MEM_alu_out[1:0];
                2'b01:   dmem.dmem_byte_enable = 4'b0011 << {MEM_alu_out[1], 1'b0};
                default: dmem.dmem_byte_enable = 4'b1111;
            endcase
        end
    end

    assign MEM_rd_data      = ((state_q == DONE) && is_load) ? load_q : MEM_alu_out;
    assign MEM_load_regfile = MEM_ctrlword.load_regfile & MEM_valid & ~misaligned;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: drives the pipeline side and plays the data
// memory by hand, checking strobes, stall, lane formatting and reset abort.

module tb_mem_stage;
    import rv32i_types::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              MEM_valid;
    rv32i_control_word MEM_ctrlword;
    rv32i_word         MEM_alu_out;
    rv32i_word         MEM_rs2_data;
    rv32i_reg          MEM_rd_num;
    logic              pipe_hold;
    logic              mem_stall;
    rv32i_word         MEM_rd_data;
    logic              MEM_load_regfile;
`ifdef MISALIGN_TRAP_EN
    logic              mem_misaligned;
`endif

    mem_stage_if dmem_bus();

    mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .MEM_valid        (MEM_valid),
        .MEM_ctrlword     (MEM_ctrlword),
        .MEM_alu_out      (MEM_alu_out),
        .MEM_rs2_data     (MEM_rs2_data),
        .MEM_rd_num       (MEM_rd_num),
        .pipe_hold        (pipe_hold),
        .dmem             (dmem_bus),
        .mem_stall        (mem_stall),
        .MEM_rd_data      (MEM_rd_data),
        .MEM_load_regfile (MEM_load_regfile)
`ifdef MISALIGN_TRAP_EN
        ,.mem_misaligned  (mem_misaligned)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int read_edges = 0;
    int stall_cycles = 0;
    logic prev_read = 1'b0;
    int e0;
    int s0;

    // Count read-strobe rising edges and stalled cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (dmem_bus.dmem_read && !prev_read) read_edges++;
        prev_read = dmem_bus.dmem_read;
        if (mem_stall) stall_cycles++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic lr, input logic [31:0] alu, input logic [31:0] rs2);
        MEM_valid    = v;
        MEM_ctrlword = '{mem_read: rd, mem_write: wr, funct3: f3, load_regfile: lr};
        MEM_alu_out  = alu;
        MEM_rs2_data = rs2;
        MEM_rd_num   = 5'd7;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    // Minimum-latency load: request, resp next cycle, then one DONE cycle.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
        set_op(1, 1, 0, f3, 1, addr, 32'h0);
        to_neg();
        check({tag, "_req"}, dmem_bus.dmem_read, 1);
        to_next();
        dmem_bus.dmem_resp  = 1'b1;
        dmem_bus.dmem_rdata = rdata;
        to_neg();
        check({tag, "_busy_stall"}, mem_stall, 1);
        to_next();
        dmem_bus.dmem_resp  = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        to_neg();
        check({tag, "_data"}, MEM_rd_data, exp);
        check({tag, "_done_stall"}, mem_stall, 0);
        to_next();
        set_op(0, 0, 0, 3'b000, 0, 32'h0, 32'h0);
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rs2, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_addr);
        set_op(1, 0, 1, f3, 0, addr, rs2);
        to_neg();
        check({tag, "_write"}, dmem_bus.dmem_write, 1);
        check({tag, "_read"}, dmem_bus.dmem_read, 0);
        check({tag, "_be"}, dmem_bus.dmem_byte_enable, exp_be);
        check({tag, "_wdata"}, dmem_bus.dmem_wdata, exp_wdata);
        check({tag, "_addr"}, dmem_bus.dmem_address, exp_addr);
        to_next();
        dmem_bus.dmem_resp = 1'b1;
        to_neg();
        check({tag, "_write_hold"}, dmem_bus.dmem_write, 1);
        to_next();
        dmem_bus.dmem_resp = 1'b0;
        to_neg();
        check({tag, "_done_be"}, dmem_bus.dmem_byte_enable, 4'b0000);
        check({tag, "_done_write"}, dmem_bus.dmem_write, 0);
        check({tag, "_done_stall"}, mem_stall, 0);
        to_next();
        set_op(0, 0, 0, 3'b000, 0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        pipe_hold = 1'b0;
        dmem_bus.dmem_resp  = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        set_op(0, 0, 0, 3'b000, 0, 32'h0, 32'h0);

        // Reset state.
        to_neg();
        check("rst_stall", mem_stall, 0);
        check("rst_read", dmem_bus.dmem_read, 0);
        check("rst_write", dmem_bus.dmem_write, 0);
        check("rst_be", dmem_bus.dmem_byte_enable, 4'b0000);
        check("rst_rd_data", MEM_rd_data, 32'h0);
        to_next();
        rst = 1'b0;

        // Non-memory instruction passes straight through.
        set_op(1, 0, 0, 3'b000, 1, 32'h1234_5678, 32'h0);
        to_neg();
        check("add_stall", mem_stall, 0);
        check("add_rd_data", MEM_rd_data, 32'h1234_5678);
        check("add_load_regfile", MEM_load_regfile, 1);
        check("add_read", dmem_bus.dmem_read, 0);
        to_next();

        // Invalid load: no access, no writeback.
        set_op(0, 1, 0, F3_W, 1, 32'h0000_0040, 32'h0);
        to_neg();
        check("inv_stall", mem_stall, 0);
        check("inv_read", dmem_bus.dmem_read, 0);
        check("inv_rd_data", MEM_rd_data, 32'h0000_0040);
        check("inv_load_regfile", MEM_load_regfile, 0);
        to_next();

        // lw 0x100 with resp three cycles after the request.
        e0 = read_edges;
        s0 = stall_cycles;
        set_op(1, 1, 0, F3_W, 1, 32'h0000_0100, 32'h0);
        to_neg();
        check("lw_read", dmem_bus.dmem_read, 1);
        check("lw_addr", dmem_bus.dmem_address, 32'h0000_0100);
        check("lw_stall", mem_stall, 1);
        check("lw_be", dmem_bus.dmem_byte_enable, 4'b0000);
        to_next();
        to_next();
        to_next();
        dmem_bus.dmem_resp  = 1'b1;
        dmem_bus.dmem_rdata = 32'hDEAD_BEEF;
        to_neg();
        check("lw_resp_read", dmem_bus.dmem_read, 1);
        to_next();
        dmem_bus.dmem_resp  = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        to_neg();
        check("lw_done_stall", mem_stall, 0);
        check("lw_done_read", dmem_bus.dmem_read, 0);
        check("lw_done_data", MEM_rd_data, 32'hDEAD_BEEF);
        to_next();
        set_op(1, 0, 0, 3'b000, 1, 32'h0000_0055, 32'h0);
        to_neg();
        check("lw_next_stall", mem_stall, 0);
        check("lw_next_data", MEM_rd_data, 32'h0000_0055);
        check("lw_stall_cycles", stall_cycles - s0, 4);
        check("lw_read_edges", read_edges - e0, 1);
        to_next();

        // Load formatting across lanes and funct3 values.
        do_load("lb_103", F3_B, 32'h0000_0103, 32'h8011_2233, 32'hFFFF_FF80);
        do_load("lbu_103", F3_BU, 32'h0000_0103, 32'h8011_2233, 32'h0000_0080);
        do_load("lb_101", F3_B, 32'h0000_0101, 32'h8011_2233, 32'h0000_0022);
        do_load("lh_102", F3_H, 32'h0000_0102, 32'h8011_2233, 32'hFFFF_8011);
        do_load("lhu_100", F3_HU, 32'h0000_0100, 32'h8011_2233, 32'h0000_2233);
        do_load("f3_011", 3'b011, 32'h0000_0100, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // Stores: lane masks and shifted data.
        do_store("sh_102", F3_H, 32'h0000_0102, 32'h0000_ABCD, 4'b1100, 32'hABCD_0000, 32'h0000_0100);
        do_store("sb_101", F3_B, 32'h0000_0101, 32'h0000_00EF, 4'b0010, 32'h0000_EF00, 32'h0000_0100);
        do_store("sb_103", F3_B, 32'h0000_0103, 32'h0000_0012, 4'b1000, 32'h1200_0000, 32'h0000_0100);
        do_store("sw_104", F3_W, 32'h0000_0104, 32'h1122_3344, 4'b1111, 32'h1122_3344, 32'h0000_0104);

        // Both strobes set: behaves as a load.
        set_op(1, 1, 1, F3_W, 1, 32'h0000_0200, 32'h0000_0099);
        to_neg();
        check("both_read", dmem_bus.dmem_read, 1);
        check("both_write", dmem_bus.dmem_write, 0);
        check("both_be", dmem_bus.dmem_byte_enable, 4'b0000);
        to_next();
        dmem_bus.dmem_resp  = 1'b1;
        dmem_bus.dmem_rdata = 32'h0BAD_F00D;
        to_next();
        dmem_bus.dmem_resp  = 1'b0;
        to_neg();
        check("both_data", MEM_rd_data, 32'h0BAD_F00D);
        to_next();

        // lw completing under a two-cycle downstream hold; stray resp in DONE.
        e0 = read_edges;
        set_op(1, 1, 0, F3_W, 1, 32'h0000_0300, 32'h0);
        to_next();
        dmem_bus.dmem_resp  = 1'b1;
        dmem_bus.dmem_rdata = 32'h1234_5678;
        to_next();
        dmem_bus.dmem_resp  = 1'b0;
        pipe_hold = 1'b1;
        to_neg();
        check("hold_d1_data", MEM_rd_data, 32'h1234_5678);
        check("hold_d1_stall", mem_stall, 0);
        to_next();
        dmem_bus.dmem_resp  = 1'b1;
        dmem_bus.dmem_rdata = 32'hFFFF_FFFF;
        to_neg();
        check("hold_d2_data", MEM_rd_data, 32'h1234_5678);
        check("hold_d2_read", dmem_bus.dmem_read, 0);
        to_next();
        dmem_bus.dmem_resp = 1'b0;
        pipe_hold = 1'b0;
        to_neg();
        check("hold_d3_data", MEM_rd_data, 32'h1234_5678);
        check("hold_d3_read", dmem_bus.dmem_read, 0);
        check("hold_d3_stall", mem_stall, 0);
        to_next();
        set_op(1, 0, 0, 3'b000, 1, 32'h0000_0077, 32'h0);
        to_neg();
        check("hold_next_data", MEM_rd_data, 32'h0000_0077);
        check("hold_read_edges", read_edges - e0, 1);
        to_next();

        // Reset mid-BUSY, stray resp afterwards.
        set_op(1, 1, 0, F3_W, 1, 32'h0000_0400, 32'h0);
        to_next();
        to_neg();
        check("abort_busy_stall", mem_stall, 1);
        #1;
        rst = 1'b1;
        #1;
        check("abort_read", dmem_bus.dmem_read, 0);
        check("abort_stall", mem_stall, 0);
        check("abort_write", dmem_bus.dmem_write, 0);
        to_next();
        rst = 1'b0;
        dmem_bus.dmem_resp  = 1'b1;
        dmem_bus.dmem_rdata = 32'hAAAA_AAAA;
        set_op(1, 0, 0, 3'b000, 1, 32'h0000_0033, 32'h0);
        to_neg();
        check("abort_add_stall", mem_stall, 0);
        check("abort_add_data", MEM_rd_data, 32'h0000_0033);
        to_next();
        dmem_bus.dmem_resp = 1'b0;
        set_op(1, 1, 0, F3_W, 1, 32'h0000_0500, 32'h0);
        to_neg();
        check("abort_reissue_read", dmem_bus.dmem_read, 1);
        check("abort_reissue_stall", mem_stall, 1);
        to_next();
        dmem_bus.dmem_resp  = 1'b1;
        dmem_bus.dmem_rdata = 32'h1357_9BDF;
        to_next();
        dmem_bus.dmem_resp = 1'b0;
        to_neg();
        check("abort_reissue_data", MEM_rd_data, 32'h1357_9BDF);
        to_next();
        set_op(0, 0, 0, 3'b000, 0, 32'h0, 32'h0);
        to_next();

`ifdef MISALIGN_TRAP_EN
        // Misaligned sw and lw are suppressed and flagged.
        set_op(1, 0, 1, F3_W, 1, 32'h0000_0101, 32'h5555_5555);
        to_neg();
        check("mis_sw_write", dmem_bus.dmem_write, 0);
        check("mis_sw_flag", mem_misaligned, 1);
        check("mis_sw_lrf", MEM_load_regfile, 0);
        check("mis_sw_stall", mem_stall, 0);
        to_next();
        set_op(1, 1, 0, F3_H, 1, 32'h0000_0103, 32'h0);
        to_neg();
        check("mis_lh_read", dmem_bus.dmem_read, 0);
        check("mis_lh_flag", mem_misaligned, 1);
        to_next();
        set_op(1, 0, 0, 3'b000, 1, 32'h0000_0101, 32'h0);
        to_neg();
        check("mis_add_flag", mem_misaligned, 0);
        check("mis_add_lrf", MEM_load_regfile, 1);
        to_next();
        set_op(0, 0, 0, 3'b000, 0, 32'h0, 32'h0);
`else
        // Without trapping, a misaligned sw proceeds with the low bits ignored.
        do_store("sw_101", F3_W, 32'h0000_0101, 32'h5555_AAAA, 4'b1111, 32'h5555_AAAA, 32'h0000_0100);
`endif

        to_next();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
